// File: rtl/guess_engine.sv
// Letter-guessing game core: latches a target word, scans each guess one slot per cycle.
// Optional build macro REPEAT_PENALTY_EN: a repeated letter also counts as a miss.
//
// state | meaning
// IDLE  | waiting for start_game
// LOAD  | latch word, clear mask/misses, pre-reveal unused slots
// WAIT  | letter_ready high, accepting one guess
// SCAN  | compare latched letter against one slot per cycle
// JUDGE | emit hit/miss, decide WIN/LOSE/WAIT
// WIN   | won held, results frozen
// LOSE  | lost held, results frozen
module guess_engine #(
    parameter int WORD_LEN   = 6,
    parameter int MAX_MISSES = 6,
    parameter int MISS_W     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_game,
    input  logic [5*WORD_LEN-1:0] word,
    input  logic                  letter_valid,
    input  logic [4:0]            letter,
    output logic                  letter_ready,
    output logic [25:0]           mask,
    output logic [WORD_LEN-1:0]   revealed,
    output logic [MISS_W-1:0]     miss_count,
    output logic                  hit,
    output logic                  miss,
    output logic                  repeat_guess,
    output logic                  won,
    output logic                  lost,
    output logic [2:0]            current_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SCAN  = 3'd3;
    localparam logic [2:0] S_JUDGE = 3'd4;
    localparam logic [2:0] S_WIN   = 3'd5;
    localparam logic [2:0] S_LOSE  = 3'd6;

    localparam int IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORD_LEN - 1);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MAX_MISSES);

    logic [2:0]            state_q, state_d;
    logic [5*WORD_LEN-1:0] word_q, word_d;
    logic [25:0]           mask_q, mask_d;
    logic [WORD_LEN-1:0]   revealed_q, revealed_d;
    logic [MISS_W-1:0]     miss_count_q, miss_count_d;
    logic [4:0]            letter_q, letter_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  match_q, match_d;
    logic                  hit_q, hit_d;
    logic                  miss_q, miss_d;
    logic                  repeat_q, repeat_d;

    logic [4:0]          slot_q [WORD_LEN];
    logic [WORD_LEN-1:0] unused_in;

    for (genvar g = 0; g < WORD_LEN; g++) begin : g_slot
        assign slot_q[g]    = word_q[5*g +: 5];
        assign unused_in[g] = (word[5*g +: 5] == 5'd31);
    end

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        mask_d       = mask_q;
        revealed_d   = revealed_q;
        miss_count_d = miss_count_q;
        letter_d     = letter_q;
        idx_d        = idx_q;
        match_d      = match_q;
        hit_d        = 1'b0;
        miss_d       = 1'b0;
        repeat_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_game) state_d = S_LOAD;
            end
            S_LOAD: begin
                word_d       = word;
                mask_d       = '0;
                miss_count_d = '0;
                revealed_d   = unused_in;
                state_d      = (&unused_in) ? S_WIN : S_WAIT;
            end
            S_WAIT: begin
                if (letter_valid) begin
                    if (letter > 5'd25) begin
                        state_d = S_WAIT;
                    end else if (mask_q[letter]) begin
                        repeat_d = 1'b1;
`ifdef REPEAT_PENALTY_EN
                        // Route through JUDGE with no match so it is charged as a miss.
                        match_d = 1'b0;
                        state_d = S_JUDGE;
`endif
                    end else begin
                        letter_d       = letter;
                        mask_d[letter] = 1'b1;
                        idx_d          = '0;
                        match_d        = 1'b0;
                        state_d        = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (slot_q[idx_q] == letter_q) begin
                    revealed_d[idx_q] = 1'b1;
                    match_d           = 1'b1;
                end
                if (idx_q == IDX_LAST) state_d = S_JUDGE;
                else                   idx_d   = idx_q + IDX_W'(1);
            end
            S_JUDGE: begin
                if (match_q) begin
                    hit_d   = 1'b1;
                    state_d = (&revealed_q) ? S_WIN : S_WAIT;
                end else begin
                    miss_d = 1'b1;
                    if (miss_count_q < MISS_MAX) miss_count_d = miss_count_q + MISS_W'(1);
                    state_d = (miss_count_d == MISS_MAX) ? S_LOSE : S_WAIT;
                end
            end
            S_WIN, S_LOSE: begin
                if (start_game) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            word_q       <= '0;
            mask_q       <= '0;
            revealed_q   <= '0;
            miss_count_q <= '0;
            letter_q     <= '0;
            idx_q        <= '0;
            match_q      <= 1'b0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            repeat_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            mask_q       <= mask_d;
            revealed_q   <= revealed_d;
            miss_count_q <= miss_count_d;
            letter_q     <= letter_d;
            idx_q        <= idx_d;
            match_q      <= match_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            repeat_q     <= repeat_d;
        end
    end

    assign letter_ready  = (state_q == S_WAIT);
    assign won           = (state_q == S_WIN);
    assign lost          = (state_q == S_LOSE);
    assign current_state = state_q;
    assign mask          = mask_q;
    assign revealed      = revealed_q;
    assign miss_count    = miss_count_q;
    assign hit           = hit_q;
    assign miss          = miss_q;
    assign repeat_guess  = repeat_q;

endmodule

// File: tb/tb_guess_engine.sv
// Directed bench for guess_engine with a 3-letter word and six allowed misses.
module tb_guess_engine;

    localparam int WL = 3;
    localparam int MM = 6;
    localparam int MW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start_game = 1'b0;
    logic [5*WL-1:0] word = '0;
    logic            letter_valid = 1'b0;
    logic [4:0]      letter = '0;
    logic            letter_ready;
    logic [25:0]     mask;
    logic [WL-1:0]   revealed;
    logic [MW-1:0]   miss_count;
    logic            hit, miss, repeat_guess, won, lost;
    logic [2:0]      current_state;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [5*WL-1:0] W_CAB = {5'd1, 5'd0, 5'd2};
    localparam logic [5*WL-1:0] W_AXA = {5'd0, 5'd31, 5'd0};

    guess_engine #(.WORD_LEN(WL), .MAX_MISSES(MM), .MISS_W(MW)) dut (
        .clk(clk), .reset(reset), .start_game(start_game), .word(word),
        .letter_valid(letter_valid), .letter(letter), .letter_ready(letter_ready),
        .mask(mask), .revealed(revealed), .miss_count(miss_count), .hit(hit),
        .miss(miss), .repeat_guess(repeat_guess), .won(won), .lost(lost),
        .current_state(current_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_game(input logic [5*WL-1:0] w);
        word       = w;
        start_game = 1'b1;
        tick();
        check("load_state", 32'(current_state), 32'd1);
        start_game = 1'b0;
        tick();
    endtask

    // Returns just after the accepting edge.
    task automatic offer(input logic [4:0] l);
        int waited = 0;
        while (!letter_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!letter_ready) check("ready_timeout", 32'(letter_ready), 32'd1);
        letter_valid = 1'b1;
        letter       = l;
        tick();
        letter_valid = 1'b0;
    endtask

    task automatic guess_full(input logic [4:0] l);
        offer(l);
        repeat (WL + 1) tick();
    endtask

    initial begin
        #3;
        check("rst_state", 32'(current_state), 32'd0);
        check("rst_outs", {mask, revealed, miss_count, hit, miss, repeat_guess, won, lost, letter_ready}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("idle_hold", 32'(current_state), 32'd0);

        // Win by guessing A, B, C on word CAB
        new_game(W_CAB);
        check("wait_ready", 32'(letter_ready), 32'd1);
        check("load_revealed", 32'(revealed), 32'b000);
        offer(5'd0);
        check("scan_entry", 32'(current_state), 32'd3);
        check("scan_not_ready", 32'(letter_ready), 32'd0);
        repeat (WL) tick();
        check("judge_state", 32'(current_state), 32'd4);
        tick();
        check("hitA", {hit, miss, revealed}, {1'b1, 1'b0, 3'b010});
        tick();
        check("hit_one_cycle", 32'(hit), 32'd0);
        guess_full(5'd1);
        check("hitB", {hit, revealed}, {1'b1, 3'b110});
        guess_full(5'd2);
        check("hitC", {hit, revealed}, {1'b1, 3'b111});
        check("won", {won, lost, current_state}, {1'b1, 1'b0, 3'd5});
        check("win_misses", 32'(miss_count), 32'd0);
        check("win_mask", 32'(mask), 32'h7);
        check("win_not_ready", 32'(letter_ready), 32'd0);

        // start_game from WIN begins a fresh game
        new_game(W_CAB);
        check("restart_clear", {won, mask, revealed, miss_count}, 32'd0);

        // Six misses Z..U lose the game
        for (int k = 1; k <= MM; k++) begin
            guess_full(5'(26 - k));
            check($sformatf("miss%0d", k), {miss, hit, miss_count}, {1'b1, 1'b0, 4'(k)});
        end
        check("lost", {lost, won, current_state}, {1'b1, 1'b0, 3'd6});
        check("lose_not_ready", 32'(letter_ready), 32'd0);
        letter_valid = 1'b1;
        letter       = 5'd0;
        repeat (3) tick();
        letter_valid = 1'b0;
        check("lose_frozen", {mask, miss_count}, {26'h3F00000, 4'd6});
        check("lose_revealed", 32'(revealed), 32'd0);
        check("lose_hold", 32'(current_state), 32'd6);

        // Unused middle slot pre-revealed; check hit latency
        new_game(W_AXA);
        check("axa_revealed", 32'(revealed), 32'b010);
        offer(5'd0);
        for (int c = 1; c <= WL; c++) begin
            tick();
            check($sformatf("no_early_hit%0d", c), 32'(hit), 32'd0);
        end
        tick();
        check("axa_hit", {hit, revealed, won}, {1'b1, 3'b111, 1'b1});

        // Repeated guess
        new_game(W_CAB);
        guess_full(5'd0);
        check("rep_first", 32'(hit), 32'd1);
        offer(5'd0);
        check("rep_pulse", 32'(repeat_guess), 32'd1);
`ifdef REPEAT_PENALTY_EN
        check("rep_judge", 32'(current_state), 32'd4);
        tick();
        check("rep_penalty", {miss, miss_count, current_state}, {1'b1, 4'd1, 3'd2});
`else
        check("rep_free", {miss, miss_count, current_state}, {1'b0, 4'd0, 3'd2});
        tick();
`endif
        check("rep_one_cycle", 32'(repeat_guess), 32'd0);

        // Out-of-range code is dropped
        offer(5'd27);
        check("bad_code", {current_state, mask, hit, miss, repeat_guess}, {3'd2, 26'h1, 3'b000});
        tick();
        check("bad_code_quiet", {current_state, hit, miss, repeat_guess}, {3'd2, 3'b000});

        // letter_valid during SCAN is ignored and not queued
        offer(5'd1);
        letter_valid = 1'b1;
        letter       = 5'd2;
        tick();
        tick();
        letter_valid = 1'b0;
        repeat (WL - 1) tick();
        check("scan_ignore", {hit, revealed, mask}, {1'b1, 3'b110, 26'h3});
        repeat (2) tick();
        check("not_queued", {current_state, mask}, {3'd2, 26'h3});

        // Asynchronous reset in the second SCAN cycle
        offer(5'd2);
        tick();
        check("pre_reset_scan", 32'(current_state), 32'd3);
        #2 reset = 1'b1;
        #1;
        check("async_rst_state", 32'(current_state), 32'd0);
        check("async_rst_outs", {mask, revealed, miss_count, hit, miss, repeat_guess, won, lost, letter_ready}, 32'd0);
        #2 reset = 1'b0;
        tick();
        check("post_reset_idle", 32'(current_state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
